// File: rtl/serial_pkg.sv
// Shared serial-link definitions: default word/counter widths and the
// receive/transmit FSM state encoding.
package serial_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned COUNT_W_DEF = 5;

    // Enumerated view of the link FSM states, for code that prefers a typed state.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_e;

    // Same encoding as plain constants, for code that holds the state in a logic vector.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

endpackage

// File: rtl/serial_in.sv
// serial_in: LSB-first serial-to-parallel receiver with a one-word holding
// register and valid/ready handshake on the parallel side.
//
// Ports:
//   clk          sole clock, rising edge
//   rstn         synchronous active-low reset
//   data_in      serial data bit (bit 0 of the word first)
//   data_valid   data_in carries a valid bit this cycle
//   data_out     assembled word, valid while out_valid=1
//   out_valid    data_out holds an unconsumed word
//   out_ready    consumer takes data_out when out_valid & out_ready
//   recv_busy    a word is partially received
//   frame_err    one-cycle pulse: word aborted before completion
//   overflow     sticky: a completed word was dropped
//   overflow_clr clears overflow (an overflow in the same cycle wins)
module serial_in
    import serial_pkg::*;
#(
    parameter int unsigned width   = WIDTH_DEF,
    parameter int unsigned count_w = COUNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             data_in,
    input  logic             data_valid,
    output logic [width-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             recv_busy,
    output logic             frame_err,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam logic [count_w-1:0] LAST_BIT = count_w'(width - 1);

    logic [0:0]         state,      state_nxt;
    logic [count_w-1:0] count,      count_nxt;
    logic [width-1:0]   shreg,      shreg_nxt;
    logic [width-1:0]   data_out_nxt;
    logic               out_valid_nxt;
    logic               frame_err_nxt;
    logic               overflow_nxt;
    logic               complete_c;

    // Next-state: bit assembly, FSM, and holding-register/handshake update.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        shreg_nxt     = shreg;
        data_out_nxt  = data_out;
        out_valid_nxt = out_valid;
        frame_err_nxt = 1'b0;
        overflow_nxt  = overflow;
        complete_c    = 1'b0;

        case (state)
            IDLE: begin
                if (data_valid) begin
                    shreg_nxt[0] = data_in;
                    if (width == 1) begin
                        complete_c = 1'b1;
                    end else begin
                        count_nxt = count_w'(1);
                        state_nxt = RECV;
                    end
                end
            end
            RECV: begin
                if (data_valid) begin
                    shreg_nxt[count] = data_in;
                    if (count == LAST_BIT) begin
                        complete_c = 1'b1;
                        count_nxt  = '0;
                        state_nxt  = IDLE;
                    end else begin
                        count_nxt = count + count_w'(1);
                    end
                end else begin
                    // Stream broke mid-word: drop the partial word and flag it.
                    shreg_nxt     = '0;
                    count_nxt     = '0;
                    frame_err_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase

        // A completed word loads the holding register if it is empty or being
        // drained this cycle; otherwise the new word is dropped.
        if (complete_c) begin
            if (!out_valid || out_ready) begin
                data_out_nxt  = shreg_nxt;
                out_valid_nxt = 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        // Set has priority over clear.
        if (complete_c && out_valid && !out_ready) begin
            overflow_nxt = 1'b1;
        end else if (overflow_clr) begin
            overflow_nxt = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            count     <= '0;
            shreg     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            recv_busy <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            shreg     <= shreg_nxt;
            data_out  <= data_out_nxt;
            out_valid <= out_valid_nxt;
            frame_err <= frame_err_nxt;
            overflow  <= overflow_nxt;
            recv_busy <= (state_nxt == RECV);
        end
    end

endmodule

// File: tb/tb_serial_in.sv
// Directed testbench for serial_in (width=32).
module tb_serial_in;

    logic        clk;
    logic        rstn;
    logic        data_in;
    logic        data_valid;
    logic [31:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        recv_busy;
    logic        frame_err;
    logic        overflow;
    logic        overflow_clr;

    int n_checks;
    int n_fail;

    serial_in #(.width(32), .count_w(5)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .recv_busy    (recv_busy),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    // Drive bits lo..hi of w, one per cycle; outputs are sampled 1ns after each edge.
    task automatic send_bits(input logic [31:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            data_in    = w[i];
            data_valid = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            data_valid = 1'b0;
            data_in    = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; data_valid = 1'b1; data_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want %h", data_out, 32'h0); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (recv_busy !== 1'b0) begin n_fail++; $display("FAIL reset_recv_busy: got %b want 0", recv_busy); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rstn = 1'b1;
        idle(1);
        n_checks++; if (recv_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", recv_busy); end
    endtask

    task automatic test_single_word();
        out_ready = 1'b1;
        send_bits(32'hA5A5_0F0F, 0, 0);
        n_checks++; if (recv_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_first: got %b want 1", recv_busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %b want 0", out_valid); end
        send_bits(32'hA5A5_0F0F, 1, 31);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
        n_checks++; if (data_out !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL single_data: got %h want %h", data_out, 32'hA5A5_0F0F); end
        n_checks++; if (recv_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_done: got %b want 0", recv_busy); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL single_frame_err: got %b want 0", frame_err); end
        idle(1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_consumed: got %b want 0", out_valid); end
        n_checks++; if (data_out !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL single_hold: got %h want %h", data_out, 32'hA5A5_0F0F); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL single_idle_ferr: got %b want 0", frame_err); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0; overflow_clr = 1'b0;
        send_bits(32'h0000_0001, 0, 31);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_first_valid: got %b want 1", out_valid); end
        n_checks++; if (data_out !== 32'h0000_0001) begin n_fail++; $display("FAIL ovf_first_data: got %h want %h", data_out, 32'h1); end
        send_bits(32'h8000_0000, 0, 30);
        n_checks++; if (recv_busy !== 1'b1) begin n_fail++; $display("FAIL ovf_b2b_busy: got %b want 1", recv_busy); end
        // Clear asserted in the same cycle the overflow occurs: set must win.
        overflow_clr = 1'b1;
        send_bits(32'h8000_0000, 31, 31);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
        n_checks++; if (data_out !== 32'h0000_0001) begin n_fail++; $display("FAIL ovf_held_data: got %h want %h", data_out, 32'h1); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_held_valid: got %b want 1", out_valid); end
        idle(1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        overflow_clr = 1'b0; out_ready = 1'b1;
        idle(1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_frame_err();
        out_ready = 1'b1;
        send_bits(32'hFFFF_FFFF, 0, 9);
        n_checks++; if (recv_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_mid: got %b want 1", recv_busy); end
        idle(1);
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_pulse: got %b want 1", frame_err); end
        n_checks++; if (recv_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy: got %b want 0", recv_busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_out_valid: got %b want 0", out_valid); end
        idle(1);
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_one_cycle: got %b want 0", frame_err); end
        out_ready = 1'b0;
        send_bits(32'hDEAD_BEEF, 0, 31);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_next_valid: got %b want 1", out_valid); end
        n_checks++; if (data_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ferr_next_data: got %h want %h", data_out, 32'hDEAD_BEEF); end
        out_ready = 1'b1;
        idle(1);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_bits(32'h1111_2222, 0, 31);
        n_checks++; if (data_out !== 32'h1111_2222) begin n_fail++; $display("FAIL b2b_first_data: got %h want %h", data_out, 32'h1111_2222); end
        send_bits(32'h3333_4444, 0, 30);
        // Consumer takes the held word in the very cycle the next word completes.
        out_ready = 1'b1;
        send_bits(32'h3333_4444, 31, 31);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
        n_checks++; if (data_out !== 32'h3333_4444) begin n_fail++; $display("FAIL b2b_data: got %h want %h", data_out, 32'h3333_4444); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
        idle(1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_word();
        out_ready = 1'b0;
        send_bits(32'hCAFE_F00D, 0, 31);
        send_bits(32'h5555_AAAA, 0, 19);
        rstn = 1'b0; data_valid = 1'b1; data_in = 1'b1; out_ready = 1'b1; overflow_clr = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL rmid_data_out: got %h want %h", data_out, 32'h0); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        n_checks++; if (recv_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", recv_busy); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rmid_frame_err: got %b want 0", frame_err); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_overflow: got %b want 0", overflow); end
        rstn = 1'b1;
        idle(1);
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rmid_post_ferr: got %b want 0", frame_err); end
        send_bits(32'h1234_5678, 0, 31);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_next_valid: got %b want 1", out_valid); end
        n_checks++; if (data_out !== 32'h1234_5678) begin n_fail++; $display("FAIL rmid_next_data: got %h want %h", data_out, 32'h1234_5678); end
        idle(1);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_drain: got %b want 0", out_valid); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        clk = 1'b0; rstn = 1'b0; data_in = 1'b0; data_valid = 1'b0;
        out_ready = 1'b0; overflow_clr = 1'b0;
        test_reset();
        test_single_word();
        test_overflow();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_in.md
SERIAL_IN -- requirements
Module: serial_in

Interface
REQ-001 Parameter width, default 32: deserialized word width in bits.
REQ-002 Parameter count_w, default 5: bit-counter width; SHALL equal clog2(width).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 data_in  input  1  serial data bit, LSB of word first.
REQ-006 data_valid  input  1  data_in is a valid bit this cycle; SHALL stay high for all width bits of a word.
REQ-007 data_out  output  width  assembled word, valid while out_valid=1.
REQ-008 out_valid  output  1  data_out holds an unconsumed word.
REQ-009 out_ready  input  1  consumer accepts data_out when out_valid&out_ready.
REQ-010 recv_busy  output  1  a word is partially received.
REQ-011 frame_err  output  1  one-cycle pulse: word aborted before completion.
REQ-012 overflow  output  1  sticky: a completed word was dropped.
REQ-013 overflow_clr  input  1  clears overflow.

Function
REQ-014 FSM SHALL have states IDLE and RECV; reset state IDLE.
REQ-015 IDLE: data_valid=1 -> capture bit into position 0, count=1, go RECV; else stay.
REQ-016 RECV: data_valid=1 -> capture bit into position count, count+1; when capturing bit width-1 -> word complete, count=0, go IDLE.
REQ-017 RECV with data_valid=0 -> discard partial word, count=0, frame_err=1 next cycle, go IDLE.
REQ-018 Bit k of the word SHALL be the k-th valid bit received (k=0 first), matching the LSB-first shift-out of the transmit side.
REQ-019 Latency: word complete on edge N -> data_out/out_valid updated at edge N, visible in cycle N+1.
REQ-020 Completion with out_valid=0, or with out_valid&out_ready same cycle: load holding register, out_valid=1, no overflow.
REQ-021 Completion with out_valid=1 and out_ready=0: new word dropped, holding register unchanged, overflow set.
REQ-022 out_valid&out_ready with no completion: out_valid cleared next cycle; data_out value then don't-care but SHALL hold last word.
REQ-023 overflow_clr and an overflow event same cycle: overflow SHALL be 1 (set wins).
REQ-024 recv_busy SHALL equal (state==RECV).
REQ-025 Back-to-back words (data_valid held high 2*width cycles) SHALL be received with no gap cycle.
REQ-026 count SHALL never exceed width-1; no wrap-around beyond one word.

Reset
REQ-027 rstn=0 at a rising edge: state=IDLE, count=0, shift register=0, data_out=0, out_valid=0, frame_err=0, overflow=0, recv_busy=0.
REQ-028 Reset mid-word or with out_valid=1 SHALL discard partial and held words without frame_err or overflow.
REQ-029 Inputs SHALL be ignored during the cycle rstn=0.

Structure
REQ-030 Shared package serial_pkg SHALL hold default width/count_w constants and the IDLE/RECV state enum, shared with the transmit side.
REQ-031 Single module; no sub-module is needed (shift register, counter, FSM and holding register all inline).

Verification
REQ-032 Send 32'hA5A5_0F0F LSB first, out_ready=1 -> out_valid one cycle, data_out=32'hA5A5_0F0F, frame_err=0.
REQ-033 Two back-to-back words 32'h0000_0001, 32'h8000_0000, out_ready=0 -> first held, second dropped, overflow=1; overflow_clr -> overflow=0.
REQ-034 data_valid dropped after 10 bits -> frame_err pulse 1 cycle, recv_busy=0, out_valid stays 0; next full word 32'hDEAD_BEEF received correctly.
REQ-035 Word completes in same cycle out_ready consumes previous word -> out_valid stays 1, data_out switches to new word, overflow=0.
REQ-036 rstn=0 after 20 bits -> all outputs 0; subsequent word 32'h1234_5678 received correctly.
